data_cache_frontend: RTL

Direct-mapped, write-through, no-write-allocate data cache between the core's load/store unit and `DataMemoryForCache`. Read hits return a word combinationally with no stall. Read misses stall the core while a 256-bit line (8 words) is fetched over the one-cycle-latency memory port. Every store is forwarded to memory as a masked word write in the same cycle, and any cached copy is updated in parallel.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_line_store.sv | 67 ++++++
 rtl/data_cache_frontend.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache front end: line geometry and the
// refill FSM state encoding.
package dcache_pkg;

  localparam int unsigned LINE_WORDS  = 8;
  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } dcache_state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Tag, valid and data arrays of the direct-mapped data cache.
// Ports:
//   clk                          clock
//   clear                        synchronous clear of every valid bit
//   rd_index/rd_offset           combinational lookup -> rd_valid, rd_tag, rd_word
//   fill_en/fill_index/fill_tag/fill_line   full-line refill, sets valid
//   wr_en/wr_index/wr_offset/wr_data/wr_mask byte-masked word write
// Tags and data have no reset; only the valid bits are cleared.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned TAG_WIDTH   = 27 - INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [2:0]             rd_offset,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [31:0]            rd_word,
  input  logic                   fill_en,
  input  logic [INDEX_WIDTH-1:0] fill_index,
  input  logic [TAG_WIDTH-1:0]   fill_tag,
  input  logic [LINE_BITS-1:0]   fill_line,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [2:0]             wr_offset,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_mask
);

  localparam int unsigned Lines = 1 << INDEX_WIDTH;

  logic [Lines-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [Lines];
  logic [LINE_BITS-1:0] data_q [Lines];

  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_tag   = tag_q[rd_index];
    rd_word  = data_q[rd_index][{rd_offset, 5'b0} +: 32];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Fill and word write never coincide: fills happen in FILL, stores only in IDLE.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_line;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          data_q[wr_index][{wr_offset, 5'b0} + 8 * b +: 8] <= wr_data[8 * b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache_frontend.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// one-cycle-latency line memory. Read hits return combinationally; a read miss
// stalls for two cycles (miss detect + FILL). Stores go straight to memory and
// update a cached copy on the same edge.
// Ports:
//   clk, reset (sync, active-high)
//   read_enable, write_enable, address, write_data, write_mask   core side
//   read_data, cache_stall                                       core side
//   mem_write_enable, mem_address, mem_write_data, mem_write_mask, mem_read_data
// Optional: define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module data_cache_frontend
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  input  logic [3:0]           write_mask,
  output logic [31:0]          read_data,
  output logic                 cache_stall,
  output logic                 mem_write_enable,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_write_data,
  output logic [3:0]           mem_write_mask,
  input  logic [LINE_BITS-1:0] mem_read_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned TAG_WIDTH = 27 - INDEX_WIDTH;

  dcache_state_e state_q, state_d;

  // Line address {tag, index} latched on the miss so FILL ignores address changes.
  logic [26:0] line_addr_q;

  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic [31:0]            rd_word;
  logic                   hit;
  logic                   store;
  logic                   read_hit;
  logic                   read_miss;

  assign index = address[INDEX_WIDTH+4:5];
  assign tag   = address[31:INDEX_WIDTH+5];
  assign hit   = rd_valid && (rd_tag == tag);

  // A store wins over a simultaneous load.
  assign store     = (state_q == StIdle) && write_enable;
  assign read_hit  = (state_q == StIdle) && read_enable && !write_enable && hit;
  assign read_miss = (state_q == StIdle) && read_enable && !write_enable && !hit;

  dcache_line_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_line_store (
    .clk        (clk),
    .clear      (reset),
    .rd_index   (index),
    .rd_offset  (address[4:2]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .fill_en    ((state_q == StFill) && !reset),
    .fill_index (line_addr_q[INDEX_WIDTH-1:0]),
    .fill_tag   (line_addr_q[26:INDEX_WIDTH]),
    .fill_line  (mem_read_data),
    .wr_en      (store && hit && !reset),
    .wr_index   (index),
    .wr_offset  (address[4:2]),
    .wr_data    (write_data),
    .wr_mask    (write_mask)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (read_miss) begin
      line_addr_q <= address[31:5];
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (read_miss) state_d = StFill;
      StFill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    cache_stall      = 1'b0;
    read_data        = 32'h0;
    mem_write_enable = store;
    mem_write_data   = write_data;
    mem_write_mask   = write_mask;
    mem_address      = address;
    unique case (state_q)
      StIdle: begin
        if (read_miss) begin
          cache_stall = 1'b1;
          mem_address = {address[31:5], 5'b0};
        end else if (read_hit) begin
          read_data = rd_word;
        end
      end
      StFill: begin
        cache_stall = 1'b1;
        mem_address = {line_addr_q, 5'b0};
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      if (read_hit)  hit_count_q  <= hit_count_q + 32'd1;
      if (read_miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  // No statistics counters in this build.
`endif

endmodule
